alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, result data width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream unit (NOT/AND/OR/ADD) presents a result.
REQ-005 SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-006 SHALL have port in_result  input  WIDTH  result word from the upstream unit.
REQ-007 SHALL have port in_carry  input  1  carry-out from the upstream unit (0 for bitwise ops).
REQ-008 SHALL have port out_valid  output  1  a buffered result is presented downstream.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the presented result.
REQ-010 SHALL have port out_result  output  WIDTH  oldest buffered result word.
REQ-011 SHALL have port out_flags  output  3  {carry, negative, zero} of out_result.
REQ-012 SHALL have port result_count  output  16  number of results accepted since reset.

Function
REQ-013 SHALL implement a 2-entry in-order buffer; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-014 SHALL use FSM states EMPTY, ONE, TWO (entries held).
REQ-015 SHALL transition EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; TWO->ONE on pop.
REQ-016 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO, from registered state only (no combinational path from out_ready).
REQ-017 SHALL drive out_valid = 1 in ONE and TWO, 0 in EMPTY.
REQ-018 SHALL present a pushed result on out_result one cycle after the push (latency 1) when the buffer was EMPTY.
REQ-019 SHALL compute flags at capture: zero = (in_result == 0); negative = in_result[WIDTH-1]; carry = in_carry.
REQ-020 SHALL, on simultaneous push and pop in ONE, present the newly pushed entry on the next cycle, keeping FIFO order.
REQ-021 SHALL hold out_result and out_flags stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL ignore in_valid, in_result and in_carry whenever in_ready = 0.
REQ-023 SHALL increment result_count by 1 per push, wrapping 16'hFFFF -> 16'h0000.

Reset
REQ-024 SHALL, while rst_n = 0, force state EMPTY, in_ready 1 after deassertion, out_valid 0, out_result 0, out_flags 0, and result_count 0.
REQ-025 SHALL discard all buffered entries on reset asserted mid-operation; no pop occurs for them.

Configuration
REQ-026 SHALL, with ALU_RESULT_PARITY_EN defined, add output out_parity (1 bit) equal to the even parity (XOR reduction) of out_result, captured and buffered with each entry.
REQ-027 SHALL, without ALU_RESULT_PARITY_EN, have no out_parity port and no parity storage.

Structure
REQ-028 SHALL take the FSM state encoding (EMPTY, ONE, TWO) and flag bit indices (ZERO=0, NEG=1, CARRY=2) from shared package alu_pkg.
REQ-029 SHALL contain one sub-module, alu_flag_gen, computing zero/negative/carry (and parity when enabled) from a result word.

Verification
REQ-030 SHALL verify reset: rst_n = 0 mid-stream with 2 entries held -> out_valid 0, out_result 16'h0000, result_count 0, in_ready 1 after release.
REQ-031 SHALL verify single pass: push 16'h00FF (output of NOT of 16'hFF00), carry 0, out_ready 1 -> next cycle out_result 16'h00FF, out_flags 3'b000.
REQ-032 SHALL verify flags: push 16'h0000 carry 1, then 16'h8000 carry 0 -> out_flags 3'b101 then 3'b010.
REQ-033 SHALL verify backpressure: out_ready 0, push 16'h1111, 16'h2222 -> in_ready 0, third word 16'h3333 ignored; raise out_ready -> outputs 16'h1111 then 16'h2222 only.
REQ-034 SHALL verify simultaneous push/pop in ONE: hold 16'hAAAA, push 16'h5555 with out_ready 1 -> state stays ONE, next out_result 16'h5555.
REQ-035 SHALL verify counter wrap: 65536 pushes from reset -> result_count 16'h0000; with ALU_RESULT_PARITY_EN, 16'h0007 -> out_parity 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU result stage: buffer FSM states and out_flags bit positions.
package alu_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_W     = 3;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream/downstream handshake bundle of the ALU result stage.
// out_parity exists only when ALU_RESULT_PARITY_EN is defined.
interface alu_result_stage_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_flags;
    logic [15:0]      result_count;
`ifdef ALU_RESULT_PARITY_EN
    logic             out_parity;
`endif

    modport master (
        output in_valid, in_result, in_carry, out_ready,
        input  in_ready, out_valid, out_result, out_flags, result_count
`ifdef ALU_RESULT_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_valid, in_result, in_carry, out_ready,
        output in_ready, out_valid, out_result, out_flags, result_count
`ifdef ALU_RESULT_PARITY_EN
        , output out_parity
`endif
    );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational flag (and optional parity, ALU_RESULT_PARITY_EN) generation for one result word.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]  result,
    input  logic              carry,
    output logic [FLAG_W-1:0] flags
`ifdef ALU_RESULT_PARITY_EN
    ,
    output logic              parity
`endif
);

    always_comb begin
        flags             = '0;
        flags[FLAG_ZERO]  = (result == '0);
        flags[FLAG_NEG]   = result[WIDTH-1];
        flags[FLAG_CARRY] = carry;
    end

`ifdef ALU_RESULT_PARITY_EN
    assign parity = ^result;
`endif

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry in-order result buffer with capture-time flags; latency 1 from push when empty.
// in_ready drops only when both entries are held and is decoded from registered state. Parity: ALU_RESULT_PARITY_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_result_stage_if.slave  bus
);

`ifdef ALU_RESULT_PARITY_EN
    localparam int EW = WIDTH + FLAG_W + 1;
`else
    localparam int EW = WIDTH + FLAG_W;
`endif

    buf_state_t        state;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [15:0]       count_q;
    logic [EW-1:0]     head_q;
    logic [EW-1:0]     tail_q;
    logic [EW-1:0]     new_entry;
    logic [FLAG_W-1:0] new_flags;
    logic              push;
    logic              pop;

`ifdef ALU_RESULT_PARITY_EN
    logic new_parity;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result (bus.in_result),
        .carry  (bus.in_carry),
        .flags  (new_flags),
        .parity (new_parity)
    );

    assign new_entry      = {new_parity, new_flags, bus.in_result};
    assign bus.out_parity = head_q[EW-1];
`else
    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result (bus.in_result),
        .carry  (bus.in_carry),
        .flags  (new_flags)
    );

    assign new_entry = {new_flags, bus.in_result};
`endif

    assign push = bus.in_valid & in_ready_q;
    assign pop  = out_valid_q & bus.out_ready;

    // head_q is always the oldest entry, so outputs come straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            if (push) begin
                count_q <= count_q + 16'd1;
            end
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_q      <= new_entry;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_q <= new_entry;
                    end else if (push) begin
                        tail_q     <= new_entry;
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q     <= tail_q;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_result   = head_q[WIDTH-1:0];
    assign bus.out_flags    = head_q[WIDTH +: FLAG_W];
    assign bus.result_count = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; out_parity checks only with ALU_RESULT_PARITY_EN.
module tb_alu_result_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_result_stage_if #(.WIDTH(16)) bus ();

    alu_result_stage #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic c);
        bus.in_valid  = v;
        bus.in_result = d;
        bus.in_carry  = c;
    endtask

    task automatic test_reset();
        drive(1'b0, 16'h0, 1'b0);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_result !== 16'h0000) begin n_fail++; $display("FAIL rst_out_result got %h want 0000", bus.out_result); end
        n_vec++; if (bus.out_flags !== 3'b000) begin n_fail++; $display("FAIL rst_out_flags got %b want 000", bus.out_flags); end
        n_vec++; if (bus.result_count !== 16'h0000) begin n_fail++; $display("FAIL rst_count got %h want 0000", bus.result_count); end
        rst_n = 1'b1;
        tick();
        n_vec++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        // fill both entries, then reset asynchronously mid-stream
        drive(1'b1, 16'h1234, 1'b0); tick();
        drive(1'b1, 16'h5678, 1'b1); tick();
        drive(1'b0, 16'h0, 1'b0);
        n_vec++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full_in_ready got %b want 0", bus.in_ready); end
        n_vec++; if (bus.result_count !== 16'h0002) begin n_fail++; $display("FAIL mid_count got %h want 0002", bus.result_count); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_result !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_out_result got %h want 0000", bus.out_result); end
        n_vec++; if (bus.result_count !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_count got %h want 0000", bus.result_count); end
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        n_vec++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_in_ready got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rel_no_stale got %b want 0", bus.out_valid); end
    endtask

    task automatic test_single_pass();
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h00FF, 1'b0); tick();
        drive(1'b0, 16'h0, 1'b0);
        n_vec++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
        n_vec++; if (bus.out_result !== 16'h00FF) begin n_fail++; $display("FAIL single_result got %h want 00ff", bus.out_result); end
        n_vec++; if (bus.out_flags !== 3'b000) begin n_fail++; $display("FAIL single_flags got %b want 000", bus.out_flags); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flags();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0000, 1'b1); tick();
        drive(1'b1, 16'h8000, 1'b0); tick();
        drive(1'b0, 16'h0, 1'b0);
        n_vec++; if (bus.out_result !== 16'h0000) begin n_fail++; $display("FAIL flags_first_result got %h want 0000", bus.out_result); end
        n_vec++; if (bus.out_flags !== 3'b101) begin n_fail++; $display("FAIL flags_zero_carry got %b want 101", bus.out_flags); end
        bus.out_ready = 1'b1;
        tick();
        n_vec++; if (bus.out_result !== 16'h8000) begin n_fail++; $display("FAIL flags_second_result got %h want 8000", bus.out_result); end
        n_vec++; if (bus.out_flags !== 3'b010) begin n_fail++; $display("FAIL flags_negative got %b want 010", bus.out_flags); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flags_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [15:0] base;
        base = bus.result_count;
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1111, 1'b0); tick();
        drive(1'b1, 16'h2222, 1'b0); tick();
        n_vec++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
        drive(1'b1, 16'h3333, 1'b1); tick(); tick();
        drive(1'b0, 16'h0, 1'b0);
        n_vec++; if (bus.out_result !== 16'h1111) begin n_fail++; $display("FAIL bp_hold_result got %h want 1111", bus.out_result); end
        n_vec++; if (bus.out_flags !== 3'b000) begin n_fail++; $display("FAIL bp_hold_flags got %b want 000", bus.out_flags); end
        n_vec++; if (bus.result_count !== base + 16'd2) begin n_fail++; $display("FAIL bp_count got %h want %h", bus.result_count, base + 16'd2); end
        bus.out_ready = 1'b1;
        tick();
        n_vec++; if (bus.out_result !== 16'h2222) begin n_fail++; $display("FAIL bp_second got %h want 2222", bus.out_result); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reopen got %b want 1", bus.in_ready); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_third_dropped got %b want 0", bus.out_valid); end
    endtask

    task automatic test_simultaneous();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 1'b0); tick();
        n_vec++; if (bus.out_result !== 16'hAAAA) begin n_fail++; $display("FAIL sim_hold got %h want aaaa", bus.out_result); end
        drive(1'b1, 16'h5555, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        drive(1'b0, 16'h0, 1'b0);
        n_vec++; if (bus.out_result !== 16'h5555) begin n_fail++; $display("FAIL sim_next got %h want 5555", bus.out_result); end
        n_vec++; if ({bus.out_valid, bus.in_ready} !== 2'b11) begin n_fail++; $display("FAIL sim_state_one got %b want 11", {bus.out_valid, bus.in_ready}); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sim_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_counter_wrap();
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, i[15:0], 1'b0);
            tick();
        end
        n_vec++; if (bus.result_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff got %h want ffff", bus.result_count); end
        drive(1'b1, 16'hFFFF, 1'b0); tick();
        drive(1'b0, 16'h0, 1'b0);
        n_vec++; if (bus.result_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got %h want 0000", bus.result_count); end
        n_vec++; if (bus.out_flags !== 3'b010) begin n_fail++; $display("FAIL wrap_last_flags got %b want 010", bus.out_flags); end
        tick();
    endtask

`ifdef ALU_RESULT_PARITY_EN
    task automatic test_parity();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0007, 1'b0); tick();
        drive(1'b1, 16'h0003, 1'b0); tick();
        drive(1'b0, 16'h0, 1'b0);
        n_vec++; if (bus.out_parity !== 1'b1) begin n_fail++; $display("FAIL parity_0007 got %b want 1", bus.out_parity); end
        bus.out_ready = 1'b1;
        tick();
        n_vec++; if (bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_0003 got %b want 0", bus.out_parity); end
        tick();
    endtask
`endif

    initial begin
        drive(1'b0, 16'h0, 1'b0);
        bus.out_ready = 1'b0;
        test_reset();
        test_single_pass();
        test_flags();
        test_backpressure();
        test_simultaneous();
        test_counter_wrap();
`ifdef ALU_RESULT_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
